// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned BE_WIDTH       = 4;
  localparam int unsigned MAX_LATENCY    = 15;
  localparam int unsigned CNT_WIDTH      = 4;
  // Widest supported request address; narrower addresses are zero-extended.
  localparam int unsigned ADDR_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic                      we;
    logic [ADDR_MAX_WIDTH-1:0] addr;
    logic [31:0]               wdata;
    logic [BE_WIDTH-1:0]       be;
  } req_t;

  function automatic logic addr_out_of_range(input logic [ADDR_MAX_WIDTH-1:0] addr,
                                             input int unsigned idx_width);
    return (addr >> (idx_width + 2)) != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable write and registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < int'(BE_WIDTH); b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency main-memory responder for the data cache's memory port.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BE_WIDTH-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int unsigned IDX_WIDTH = $clog2(MEM_DEPTH_WORDS);
  localparam logic [CNT_WIDTH-1:0] WAIT_INIT = CNT_WIDTH'(LATENCY >= 2 ? LATENCY - 2 : 0);

  if (DATA_WIDTH != 32 || LATENCY < 1 || LATENCY > MAX_LATENCY ||
      (MEM_DEPTH_WORDS & (MEM_DEPTH_WORDS - 1)) != 0 ||
      ADDR_WIDTH > ADDR_MAX_WIDTH || ADDR_WIDTH < IDX_WIDTH + 2) begin : g_bad_params
    $error("data_mem_ctrl: unsupported parameter set");
  end

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  req_t                  req_q, req_d, acc;
  logic                  enter_resp;
  logic                  acc_err;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  unused_addr_lo;

  always_comb begin
    req_d                       = '0;
    req_d.we                    = req_we_i;
    req_d.addr[ADDR_WIDTH-1:0]  = req_addr_i;
    req_d.wdata                 = req_wdata_i;
    req_d.be                    = req_be_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req_valid_i) req_q <= req_d;
    end
  end

  // With LATENCY=1 the array is accessed on the accept edge, before req_q holds the request.
  assign acc = (state_q == StIdle) ? req_d : req_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_err = addr_out_of_range(acc.addr, IDX_WIDTH);
  assign rsp_err = addr_out_of_range(req_q.addr, IDX_WIDTH);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc.addr[ADDR_MAX_WIDTH-1:IDX_WIDTH+2];
  assign acc_err        = 1'b0;
  assign rsp_err        = 1'b0;
`endif
  assign unused_addr_lo = ^acc.addr[1:0];

  dmem_array #(
    .DEPTH      (MEM_DEPTH_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clk   (clk_i),
    .en    (enter_resp & ~rst_i),
    .we    (acc.we & ~acc_err),
    .idx   (acc.addr[IDX_WIDTH+1:2]),
    .wdata (acc.wdata),
    .be    (acc.be),
    .rdata (arr_rdata)
  );

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = rsp_valid_o & rsp_err;
  assign rsp_rdata_o = (rsp_valid_o && !req_q.we && !rsp_err) ? arr_rdata : '0;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Main-memory responder at the far end of the data cache's memory port.
- Accepts one read or write request at a time over a valid/ready handshake and stores data in an internal word array.
- Returns a response after a fixed, parameterised latency, so cache miss and write-through timing can be exercised against realistic memory delay.
- Sits between the data cache and the top level. The cache remains the only initiator.

Parameters:
- ADDR_WIDTH, 32: request address width in bits.
- DATA_WIDTH, 32: word width in bits; must be 32, which gives 4 byte enables.
- MEM_DEPTH_WORDS, 4096: number of words in the array; must be a power of two.
- LATENCY, 4: cycles from request acceptance to the first rsp_valid_o; legal range is 1 to 15.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_be_i  in  4  byte enables; bit n covers bits 8n+7 to 8n.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  initiator accepts the response.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses.
- rsp_err_o  out  1  address error; see Optional Feature.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - FSM goes to IDLE and the latency counter clears to 0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready_o=1. When req_valid_i is high, the request is accepted. At the accept edge the controller latches we, addr, wdata and be, then moves to WAIT, or directly to RESP if LATENCY=1.
  - WAIT: req_ready_o=0. The latency counter decrements each cycle; at terminal count the controller goes to RESP.
  - RESP: rsp_valid_o=1. Leaves on rsp_ready_i=1 and returns to IDLE.
- Latency: if acceptance is at edge T, rsp_valid_o is first high in the cycle after edge T+LATENCY-1. That is, LATENCY cycles after the accept cycle.
- Back-to-back: the next request can be accepted no earlier than the cycle after response acceptance. Minimum request period is LATENCY+1 cycles.
- Only one request is outstanding at a time; there is no pipelining.
- Array access happens at the edge that enters RESP.
  - Read: rsp_rdata_o is loaded from array[word index].
  - Write: only bytes with be=1 are updated; rsp_rdata_o is 0.
  - A write with be=0 is a no-op but still produces a response.
- Word index is req_addr_i[log2(MEM_DEPTH_WORDS)+1 : 2]. Address bits [1:0] are ignored.
- Without the optional feature, higher address bits are ignored, so addresses wrap modulo the array size.
- rsp_rdata_o and rsp_err_o are held stable for the whole of RESP, including during rsp_ready_i=0 backpressure.
- Read-after-write: a read accepted after a write's response sees the written data.
- Inputs are don't-care outside IDLE. req_* changes while the controller is busy are ignored.
- Reset mid-operation: an in-flight request is discarded and no response is produced.
  - A write that has not yet reached RESP is not committed.
  - Reset in the same cycle as req_valid_i=1 means the request is not accepted.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined: any address bit at or above log2(MEM_DEPTH_WORDS)+2 being 1 is an error.
  - The response carries rsp_err_o=1 and rsp_rdata_o=0.
  - A write is suppressed.
  - Latency and handshake are unchanged.
- Undefined: rsp_err_o is tied to 0 and addresses wrap.

Decomposition:
- Package dmem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the request struct (we, addr, wdata, be);
  - constants for byte-enable width and maximum latency.
- One sub-module, dmem_array: a single-port word array with byte-enable write and registered read.
- The controller FSM and counter live in data_mem_ctrl.

Test Plan:
- Write-then-read:
  - Stimulus: write 0xDEADBEEF to address 0x100 with be=0xF, then read 0x100.
  - Response: the write response arrives exactly 4 cycles after accept with rdata 0; the read returns 0xDEADBEEF.
- Byte enables:
  - Stimulus: preload 0x11223344 at address 0x20, write 0xAABBCCDD with be=0x5, then read.
  - Response: the read returns 0x11BB33DD.
- Backpressure:
  - Stimulus: read with rsp_ready_i held at 0 for 6 cycles.
  - Response: rsp_valid_o and rsp_rdata_o stay stable; req_ready_o stays 0 until the cycle after rsp_ready_i=1.
- Minimum latency and throughput:
  - Stimulus: set LATENCY=1, issue 3 reads with rsp_ready_i=1.
  - Response: each response arrives 1 cycle after its accept, and accepts are 2 cycles apart.
- Reset mid-operation:
  - Stimulus: pulse rst_i in WAIT during a write of 0x12345678 to 0x40, then read 0x40.
  - Response: no response to the write; the read returns the old value.
- Address wrap:
  - Stimulus: with DEPTH=4096 and the macro undefined, write 0x55 to 0x4004, then read 0x0004.
  - Response: the read returns 0x55.
  - With the macro defined, the same write has rsp_err_o=1, and a following read of 0x0004 returns the old value.
